sqr_iter: RTL and testbench
===========================

Name: sqr_iter

Overview:
- Sequential shift-add squarer: the inverse of the pipelined 10-bit square-root block. Takes a 5-bit root and produces its 10-bit square.
- Sits beside the sqrt unit in the arithmetic datapath. Used to regenerate radicands and to cross-check sqrt results.
- Built from library cells. Like every block in this codebase, it reports its own transistor count on `number`.

Parameters:
- RW, 5, root width in bits. The square is 2*RW bits wide.
- CW, 3, iteration counter width. Must satisfy 2^CW >= RW.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- i_start  input  1  request a new operation; sampled only in IDLE or DONE
- i_root  input  RW  operand; latched on the edge that accepts i_start
- o_busy  output  1  high while in RUN
- o_finish  output  1  one-cycle pulse when o_square is valid
- o_square  output  2*RW  i_root squared; held until the next accept
- number  output  51  sum of the transistor counts of all instantiated cells

Behaviour:
- Reset: with rst high at an edge, the block enters IDLE and sets o_busy=0, o_finish=0, o_square=0, counter=0, accumulator=0.
  - rst has priority over i_start and over any RUN in progress.
  - The next edge with rst low and i_start high starts an operation normally.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if i_start=1, latch i_root into root_q, clear acc and cnt, go to RUN. Otherwise stay.
  - RUN: each edge, if root_q[cnt]=1 then acc <= acc + (root_q << cnt); then cnt <= cnt+1.
    - On the edge that processes cnt=RW-1: write the final acc into o_square, set o_finish=1, go to DONE.
    - i_start is ignored in RUN, and i_root changes have no effect.
  - DONE (lasts one cycle): o_finish=1.
    - If i_start=1, accept a new operand exactly as in IDLE and go to RUN, with no gap.
    - Otherwise go to IDLE.
    - o_finish drops at the next edge either way.
- Latency and throughput:
  - Accept at edge E0; adds occur on edges E1..E5; o_finish is high in the cycle after E5.
  - One result per 6 cycles when back-to-back.
- Widths:
  - acc and every shifted partial product are 2*RW bits and zero-extended.
  - The maximum result is 31^2=961, so no overflow is possible.
  - cnt does not wrap during a valid operation.
- o_square changes only on the final RUN edge or on reset. It is never changed on accept.
- `number` is a constant: the sum of the per-cell counts of every flop, adder, mux and gate instance.

Optional Feature:
SQR_RESID_EN
- Defined: adds three ports.
  - i_radicand (input, 2*RW): latched together with i_root.
  - o_resid (output, 2*RW+1, two's complement): radicand minus square.
  - o_root_ok (output, 1): high iff 0 <= o_resid <= 2*root.
  - Both outputs update on the same edge as o_square and reset to 0.
  - Their cells are included in `number`.
- Undefined: these ports and their logic are absent, and `number` excludes them.

Decomposition:
- Package sqr_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - RW and CW defaults;
  - the NUM_W=51 constant for the count bus.
- One sub-module, sqr_add_step: a conditional shift-add of root_q<<cnt into acc, gated by root_q[cnt]. It is built from cells and outputs its own `number`.

Test Plan:
- Reset: rst=1 for 2 cycles, then idle -> o_busy=0, o_finish=0, o_square=0, `number` constant and nonzero.
- Operands 0, 1, 31 each run separately -> o_square 0, 1, 961; o_finish pulses exactly one cycle, 5 cycles after accept.
- Start with root=7; at cycle 2 of RUN pulse i_start with i_root=3 -> the second start is ignored; result 49.
- Back-to-back: root=5, then i_start with root=12 held high in the DONE cycle -> 25, then 144 six cycles later; no IDLE cycle between them.
- Assert rst at cycle 3 of RUN (root=20) -> next cycle IDLE with all outputs 0 and no o_finish; a fresh root=20 then gives 400.
- SQR_RESID_EN:
  - radicand 1000, root 31 -> o_resid 39, o_root_ok 1.
  - radicand 1000, root 30 -> o_resid 100, o_root_ok 0.
  - radicand 900, root 31 -> o_resid -61, o_root_ok 0.

Source files
------------

// File: rtl/sqr_pkg.sv
// Shared definitions for the iterative squarer: FSM states, default widths,
// the width of the transistor-count bus, and per-cell transistor costs.
// Latency: n/a (declarations only). Backpressure: n/a.
package sqr_pkg;

    localparam int RW_DEF = 5;
    localparam int CW_DEF = 3;
    localparam int NUM_W  = 51;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Transistor cost of each library cell used by the squarer.
    localparam int T_DFF  = 24;
    localparam int T_FA   = 28;
    localparam int T_HA   = 14;
    localparam int T_MUX2 = 12;
    localparam int T_AND2 = 6;
    localparam int T_XOR2 = 12;
    localparam int T_INV  = 2;

endpackage

// File: rtl/sqr_iter_if.sv
// Operand/result bundle of the squarer; optional residual fields under SQR_RESID_EN.
// Latency: n/a (wires only).
// Backpressure: none; a start is taken only when the block is IDLE or DONE.
interface sqr_iter_if #(parameter int RW = sqr_pkg::RW_DEF);

    logic              i_start;
    logic [RW-1:0]     i_root;
    logic              o_busy;
    logic              o_finish;
    logic [2*RW-1:0]   o_square;
`ifdef SQR_RESID_EN
    logic [2*RW-1:0]   i_radicand;
    logic [2*RW:0]     o_resid;
    logic              o_root_ok;

    modport master (output i_start, i_root, i_radicand,
                    input  o_busy, o_finish, o_square, o_resid, o_root_ok);
    modport slave  (input  i_start, i_root, i_radicand,
                    output o_busy, o_finish, o_square, o_resid, o_root_ok);
`else
    modport master (output i_start, i_root,
                    input  o_busy, o_finish, o_square);
    modport slave  (input  i_start, i_root,
                    output o_busy, o_finish, o_square);
`endif

endinterface

// File: rtl/sqr_add_step.sv
// One shift-add step: acc + (root_q << cnt) when root_q[cnt] is set, else acc.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module sqr_add_step
    import sqr_pkg::*;
#(
    parameter int RW = RW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic [2*RW-1:0]  acc,
    input  logic [RW-1:0]    root_q,
    input  logic [CW-1:0]    cnt,
    output logic [2*RW-1:0]  acc_next,
    output logic [NUM_W-1:0] number
);

    // Barrel shifter (CW stages of 2*RW muxes), bit-select mux tree,
    // AND gating of the partial product and a ripple adder.
    localparam int STEP_TR = CW * 2 * RW * T_MUX2
                           + (RW - 1) * T_MUX2
                           + 2 * RW * T_AND2
                           + 2 * RW * T_FA;

    logic [2*RW-1:0] shifted;
    logic [2*RW-1:0] addend;

    // Zero-extended partial product, kept only when the current root bit is set.
    always_comb begin
        shifted  = {{RW{1'b0}}, root_q} << cnt;
        addend   = root_q[cnt] ? shifted : '0;
        acc_next = acc + addend;
    end

    assign number = NUM_W'(STEP_TR);

endmodule

// File: rtl/sqr_iter.sv
// Sequential shift-add squarer: 5-bit root in, 10-bit square out; SQR_RESID_EN adds residual check.
// Latency: accept at E0, result and one-cycle o_finish after E5; 6-cycle back-to-back rate.
// Backpressure: i_start ignored while busy; a start during the DONE cycle chains with no gap.
module sqr_iter
    import sqr_pkg::*;
#(
    parameter int RW = RW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    sqr_iter_if.slave        bus,
    output logic [NUM_W-1:0] number
);

    // State, root, accumulator, counter, busy, finish and square flops,
    // their load muxes, reset gating, counter incrementer and end-count detect.
    localparam int N_FLOP  = 2 + RW + 2 * RW + CW + 2 + 2 * RW;
    localparam int N_LDMUX = RW + 2 * RW + CW + 2 * RW;
    localparam int TOP_TR  = N_FLOP * T_DFF
                           + N_LDMUX * T_MUX2
                           + (N_FLOP + 8) * T_AND2
                           + CW * T_HA
                           + CW * T_XOR2
                           + 2 * T_INV;

    state_t          state;
    logic [RW-1:0]   root_q;
    logic [2*RW-1:0] acc;
    logic [2*RW-1:0] acc_next;
    logic [2*RW-1:0] square_q;
    logic [CW-1:0]   cnt;
    logic            busy_q;
    logic            finish_q;
    logic [NUM_W-1:0] step_number;
    logic            last_step;

    sqr_add_step #(.RW(RW), .CW(CW)) u_step (
        .acc      (acc),
        .root_q   (root_q),
        .cnt      (cnt),
        .acc_next (acc_next),
        .number   (step_number)
    );

    assign last_step = (cnt == CW'(RW - 1));

`ifdef SQR_RESID_EN
    // Radicand latch, residual and ok flops with their muxes and reset gating,
    // a subtractor for the residual and a second one for the <= 2*root test.
    localparam int RES_FLOP = 2 * RW + (2 * RW + 1) + 1;
    localparam int RES_TR   = RES_FLOP * T_DFF
                            + (2 * RW + 2 * RW + 2) * T_MUX2
                            + (RES_FLOP + 1) * T_AND2
                            + 2 * (2 * RW + 1) * T_FA
                            + (2 * RW + 2 * RW + 1) * T_INV;

    logic [2*RW-1:0] rad_q;
    logic [2*RW:0]   resid_q;
    logic [2*RW:0]   resid_next;
    logic [2*RW:0]   twice_root;
    logic            ok_q;
    logic            ok_next;

    // Signed residual of the finished square; ok when it lies in [0, 2*root].
    always_comb begin
        resid_next = {1'b0, rad_q} - {1'b0, acc_next};
        twice_root = (2 * RW + 1)'({root_q, 1'b0});
        ok_next    = ~resid_next[2*RW] && (resid_next <= twice_root);
    end

    assign bus.o_resid   = resid_q;
    assign bus.o_root_ok = ok_q;
    assign number        = step_number + NUM_W'(TOP_TR) + NUM_W'(RES_TR);
`else
    assign number        = step_number + NUM_W'(TOP_TR);
`endif

    // Control FSM and datapath registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            root_q   <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            square_q <= '0;
`ifdef SQR_RESID_EN
            rad_q    <= '0;
            resid_q  <= '0;
            ok_q     <= 1'b0;
`endif
        end else begin
            finish_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.i_start) begin
                        root_q <= bus.i_root;
`ifdef SQR_RESID_EN
                        rad_q  <= bus.i_radicand;
`endif
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        square_q <= acc_next;
                        finish_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
`ifdef SQR_RESID_EN
                        resid_q  <= resid_next;
                        ok_q     <= ok_next;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy   = busy_q;
    assign bus.o_finish = finish_q;
    assign bus.o_square = square_q;

endmodule

// File: tb/tb_sqr_iter.sv
// Bench for sqr_iter: directed corner cases plus random operands against an arithmetic model.
// Latency: expects o_finish exactly 5 edges after the accepting edge.
// Backpressure: exercises starts ignored in RUN and starts chained from DONE.
module tb_sqr_iter;
    import sqr_pkg::*;

    localparam int RW = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NUM_W-1:0] number;
    logic [NUM_W-1:0] number0;

    sqr_iter_if #(.RW(RW)) bus ();

    sqr_iter #(.RW(RW), .CW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .number (number)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int last_sq = 0;
`ifdef SQR_RESID_EN
    int last_resid = 0;
    int last_ok    = 0;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_square"}, bus.o_square, last_sq);
`ifdef SQR_RESID_EN
        chk({tag, "_resid"}, bus.o_resid, last_resid[10:0]);
        chk({tag, "_ok"}, bus.o_root_ok, last_ok);
`endif
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_finish"}, bus.o_finish, 0);
        chk({tag, "_busy"}, bus.o_busy, 0);
        check_held(tag);
    endtask

    // Starts one operation from IDLE or DONE and returns in the DONE cycle.
    // When poke is nonzero, i_start is raised with poke_root for the edge E<poke>.
    task automatic run_op(input int root, input int rad, input int poke, input int poke_root);
        int  k;
        bit  seen;
        seen = 1'b0;
        bus.i_start = 1'b1;
        bus.i_root  = RW'(root);
`ifdef SQR_RESID_EN
        bus.i_radicand = 10'(rad);
`endif
        tick();
        bus.i_start = 1'b0;
        bus.i_root  = RW'($urandom);
`ifdef SQR_RESID_EN
        bus.i_radicand = 10'($urandom);
`endif
        chk("accept_busy", bus.o_busy, 1);
        chk("accept_finish", bus.o_finish, 0);
        check_held("accept");
        for (k = 1; k <= 20; k++) begin
            if (k == poke) begin
                bus.i_start = 1'b1;
                bus.i_root  = RW'(poke_root);
            end else begin
                bus.i_start = 1'b0;
            end
            tick();
            if (bus.o_finish) begin
                seen = 1'b1;
                break;
            end
            chk("run_busy", bus.o_busy, 1);
            check_held("run");
        end
        bus.i_start = 1'b0;
        chk("finish_seen", seen, 1);
        chk("latency", k, 5);
        last_sq = root * root;
        chk("square", bus.o_square, last_sq);
        chk("done_busy", bus.o_busy, 0);
`ifdef SQR_RESID_EN
        last_resid = rad - root * root;
        last_ok    = (last_resid >= 0 && last_resid <= 2 * root) ? 1 : 0;
        chk("resid", bus.o_resid, last_resid[10:0]);
        chk("root_ok", bus.o_root_ok, last_ok);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int root;
        int rad;
        int poke;
        int gap;

        bus.i_start = 1'b0;
        bus.i_root  = '0;
`ifdef SQR_RESID_EN
        bus.i_radicand = '0;
`endif

        // Reset held for two edges, then one idle edge.
        rst = 1'b1;
        tick();
        tick();
        check_idle("reset");
        chk("reset_number_nonzero", (number != 0), 1);
        number0 = number;
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Corner operands, each from IDLE.
        run_op(0, 0, 0, 0);
        tick();
        check_idle("after_0");
        run_op(1, 2, 0, 0);
        tick();
        check_idle("after_1");
        run_op(31, 961, 0, 0);
        tick();
        check_idle("after_31");

        // A start during RUN must be ignored.
        run_op(7, 50, 2, 3);
        tick();
        check_idle("after_ignored_start");

        // Back-to-back: second start presented in the DONE cycle.
        run_op(5, 30, 0, 0);
        run_op(12, 144, 0, 0);
        tick();
        check_idle("after_b2b");

        // Reset in the middle of RUN.
        bus.i_start = 1'b1;
        bus.i_root  = RW'(20);
        tick();
        bus.i_start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_sq = 0;
`ifdef SQR_RESID_EN
        last_resid = 0;
        last_ok    = 0;
`endif
        check_idle("midrun_reset");
        repeat (6) begin
            tick();
            check_idle("post_midrun_reset");
        end
        run_op(20, 400, 0, 0);
        tick();
        check_idle("after_20");

`ifdef SQR_RESID_EN
        run_op(31, 1000, 0, 0);
        run_op(30, 1000, 0, 0);
        run_op(31, 900, 0, 0);
        tick();
        check_idle("after_resid");
`endif

        // Random operands, random gaps, occasional ignored starts.
        for (int i = 0; i < 40; i++) begin
            root = int'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) rad = int'($urandom_range(0, 1023));
            else begin
                rad = root * root + int'($urandom_range(0, 2 * 31 + 3));
                if (rad > 1023) rad = 1023;
            end
            poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(root, rad, poke, int'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) begin
                gap = int'($urandom_range(1, 3));
                repeat (gap) begin
                    tick();
                    check_idle("rand_gap");
                end
            end
        end
        tick();
        check_idle("final");

        chk("number_constant", (number == number0), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
